// File: rtl/moxie_wb_arbiter_if.sv
// moxie_wb_arbiter_if: one 16-bit Wishbone link (request, read data, ack, err).
// master modport = bus-master side; slave modport = bus-slave side.
interface moxie_wb_arbiter_if;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic [31:0] adr;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output dat_w, adr, sel, we, cyc, stb,
    input  dat_r, ack
  );

  modport slave (
    input  dat_w, adr, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/moxie_wb_arbiter.sv
// moxie_wb_arbiter: round-robin two-master Wishbone arbiter with ack watchdog.
// Ports: clk_i, rst_n_i, m0/m1 (slave side of each master), s (to slave), grant_o, timeout_o.
module moxie_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  moxie_wb_arbiter_if.slave         m0,
  moxie_wb_arbiter_if.slave         m1,
  moxie_wb_arbiter_if.master        s,
  output logic [1:0]                grant_o,
  output logic                      timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_ONE  = TW'(1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          abort_q, abort_d;
  logic          stb_w;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wd_d     = wd_q;
    abort_d  = 1'b0;
    grant_o  = 2'b00;
    stb_w    = 1'b0;
    s.adr    = '0;
    s.dat_w  = '0;
    s.sel    = '0;
    s.we     = 1'b0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;

    unique case (state_q)
      IDLE: begin
        // last_q = 1 means m1 was served most recently, so m0 wins a tie
        if (m0.cyc && (!m1.cyc || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1.cyc) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        grant_o = 2'b01;
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
        s.sel   = m0.sel;
        s.we    = m0.we;
        s.cyc   = m0.cyc & ~abort_q;
        stb_w   = m0.stb & m0.cyc & ~abort_q;
        m0.ack  = s.ack & stb_w;
        m0.err  = abort_q;
        if (!m0.cyc) state_d = IDLE;
      end
      GNT1: begin
        grant_o = 2'b10;
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
        s.sel   = m1.sel;
        s.we    = m1.we;
        s.cyc   = m1.cyc & ~abort_q;
        stb_w   = m1.stb & m1.cyc & ~abort_q;
        m1.ack  = s.ack & stb_w;
        m1.err  = abort_q;
        if (!m1.cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    s.stb = stb_w;

    // an ack in the final wait cycle beats the abort
    abort_d = stb_w & ~s.ack & (wd_q == WD_LAST);
    if (!stb_w || s.ack || abort_d) begin
      wd_d = '0;
    end else if (wd_q != '1) begin
      wd_d = wd_q + WD_ONE;
    end
  end

  assign timeout_o = abort_q;

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// tb_moxie_wb_arbiter: directed scenarios plus randomized traffic
// against a cycle-level model of the arbitration and watchdog rules.
module tb_moxie_wb_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       tmo;

  moxie_wb_arbiter_if m0 ();
  moxie_wb_arbiter_if m1 ();
  moxie_wb_arbiter_if sb ();

  moxie_wb_arbiter #(.TIMEOUT(TO), .TW(16)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .m0       (m0),
    .m1       (m1),
    .s        (sb),
    .grant_o  (grant),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_all();
    m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.sel = 0; m0.adr = 0; m0.dat_w = 0;
    m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.sel = 0; m1.adr = 0; m1.dat_w = 0;
    sb.ack = 0; sb.dat_r = 0; sb.err = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    m0.cyc = 1'b1;
    @(posedge clk);
    #2;
    total_n++;
    if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant);
    else pass_n++;
    total_n++;
    if ({sb.cyc, sb.stb, tmo} !== 3'b000)
      $display("FAIL reset_cyc_stb_tmo: got %b want 000", {sb.cyc, sb.stb, tmo});
    else pass_n++;
    total_n++;
    if ({m0.ack, m0.err, m1.ack, m1.err} !== 4'b0000)
      $display("FAIL reset_ack_err: got %b want 0000", {m0.ack, m0.err, m1.ack, m1.err});
    else pass_n++;
    total_n++;
    if ({sb.adr, sb.sel, sb.we} !== 35'd0)
      $display("FAIL reset_req: got %h want 0", {sb.adr, sb.sel, sb.we});
    else pass_n++;
    m0.cyc = 1'b0;
    settle();
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0] want [8];
    want = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin m0.cyc = 1; m1.cyc = 1; end
      if (i == 2) m0.cyc = 0;
      if (i == 5) m1.cyc = 0;
      if (i == 6) begin m0.cyc = 1; m1.cyc = 1; end
      settle();
      total_n++;
      if (grant !== want[i])
        $display("FAIL contention_grant[%0d]: got %b want %b", i, grant, want[i]);
      else pass_n++;
    end
    tick();
    idle_all();
    tick();
    settle();
    total_n++;
    if (grant !== 2'b00) $display("FAIL contention_release: got %b want 00", grant);
    else pass_n++;
  endtask

  task automatic test_single();
    tick();
    m0.cyc = 1; m0.stb = 1; m0.we = 0; m0.sel = 2'b11; m0.adr = 32'h0000_1000;
    settle();
    total_n++;
    if (grant !== 2'b00) $display("FAIL single_pre_grant: got %b want 00", grant);
    else pass_n++;
    tick();
    settle();
    total_n++;
    if ({grant, sb.stb, sb.adr} !== {2'b01, 1'b1, 32'h0000_1000})
      $display("FAIL single_grant_adr: got %b %b %h want 01 1 00001000", grant, sb.stb, sb.adr);
    else pass_n++;
    tick();
    settle();
    total_n++;
    if (m0.ack !== 1'b0) $display("FAIL single_early_ack: got %b want 0", m0.ack);
    else pass_n++;
    tick();
    sb.ack = 1; sb.dat_r = 16'hBEEF;
    settle();
    total_n++;
    if ({m0.ack, m1.ack, m0.dat_r} !== {1'b1, 1'b0, 16'hBEEF})
      $display("FAIL single_ack: got %b %b %h want 1 0 beef", m0.ack, m1.ack, m0.dat_r);
    else pass_n++;
    tick();
    sb.ack = 0; m0.cyc = 0; m0.stb = 0;
    settle();
    total_n++;
    if ({m0.ack, grant} !== {1'b0, 2'b01})
      $display("FAIL single_after: got %b %b want 0 01", m0.ack, grant);
    else pass_n++;
    tick();
    settle();
    total_n++;
    if (grant !== 2'b00) $display("FAIL single_release: got %b want 00", grant);
    else pass_n++;
  endtask

  task automatic test_lock();
    logic [1:0] sels [3];
    sels = '{2'b10, 2'b01, 2'b11};
    tick();
    m0.cyc = 1;
    settle();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) m1.cyc = 1;
      m0.stb = 1; m0.we = 1; m0.sel = sels[i];
      m0.dat_w = 16'h1111 * 16'(i + 1);
      sb.ack = 1;
      settle();
      total_n++;
      if ({grant, sb.sel, sb.we, sb.dat_w, m0.ack, m1.ack} !==
          {2'b01, sels[i], 1'b1, 16'h1111 * 16'(i + 1), 1'b1, 1'b0})
        $display("FAIL lock_write[%0d]: got %b %b %b %h %b %b", i,
                 grant, sb.sel, sb.we, sb.dat_w, m0.ack, m1.ack);
      else pass_n++;
    end
    tick();
    m0.cyc = 0; m0.stb = 0; m0.we = 0; sb.ack = 0;
    settle();
    total_n++;
    if (grant !== 2'b01) $display("FAIL lock_hold: got %b want 01", grant);
    else pass_n++;
    tick();
    settle();
    total_n++;
    if (grant !== 2'b00) $display("FAIL lock_gap: got %b want 00", grant);
    else pass_n++;
    tick();
    settle();
    total_n++;
    if (grant !== 2'b10) $display("FAIL lock_handover: got %b want 10", grant);
    else pass_n++;
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_timeout();
    tick();
    m1.cyc = 1; m1.stb = 1; m1.adr = 32'h0000_2000;
    settle();
    for (int k = 0; k < TO; k++) begin
      tick();
      settle();
      total_n++;
      if ({m1.err, tmo, sb.stb} !== 3'b001)
        $display("FAIL timeout_wait[%0d]: got %b want 001", k, {m1.err, tmo, sb.stb});
      else pass_n++;
    end
    tick();
    settle();
    total_n++;
    if ({m1.err, tmo, sb.stb, sb.cyc, grant, m0.err} !== 7'b1100100)
      $display("FAIL timeout_abort: got %b want 1100100",
               {m1.err, tmo, sb.stb, sb.cyc, grant, m0.err});
    else pass_n++;
    tick();
    settle();
    total_n++;
    if ({m1.err, tmo, sb.stb} !== 3'b001)
      $display("FAIL timeout_retry: got %b want 001", {m1.err, tmo, sb.stb});
    else pass_n++;
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_tie();
    tick();
    m0.cyc = 1; m0.stb = 1;
    settle();
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      settle();
      total_n++;
      if ({m0.ack, m0.err} !== 2'b00)
        $display("FAIL tie_wait[%0d]: got %b want 00", k, {m0.ack, m0.err});
      else pass_n++;
    end
    tick();
    sb.ack = 1;
    settle();
    total_n++;
    if ({m0.ack, m0.err, tmo} !== 3'b100)
      $display("FAIL tie_ack: got %b want 100", {m0.ack, m0.err, tmo});
    else pass_n++;
    tick();
    sb.ack = 0; m0.cyc = 0; m0.stb = 0;
    settle();
    total_n++;
    if ({m0.err, tmo} !== 2'b00)
      $display("FAIL tie_no_abort: got %b want 00", {m0.err, tmo});
    else pass_n++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    m1.cyc = 1; m1.stb = 1;
    settle();
    tick();
    settle();
    total_n++;
    if ({grant, sb.cyc} !== 3'b101)
      $display("FAIL rmid_granted: got %b want 101", {grant, sb.cyc});
    else pass_n++;
    #2;
    sb.ack = 1;
    #1;
    rst_n = 1'b0;
    #1;
    total_n++;
    if ({grant, sb.cyc, sb.stb, m1.ack} !== 5'b00000)
      $display("FAIL rmid_async: got %b want 00000", {grant, sb.cyc, sb.stb, m1.ack});
    else pass_n++;
    idle_all();
    settle();
    rst_n = 1'b1;
    tick();
    m0.cyc = 1; m1.cyc = 1;
    settle();
    tick();
    settle();
    total_n++;
    if (grant !== 2'b01) $display("FAIL rmid_first_win: got %b want 01", grant);
    else pass_n++;
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_random();
    int         owner;
    int         last;
    int         waited;
    bit         abrt;
    bit         cq [2];
    bit         st [2];
    bit         ack;
    bit         stb_eff;
    bit         new_abrt;
    logic [31:0] ra [2];
    logic [15:0] rd [2];
    logic [1:0]  rs [2];
    bit          rw [2];
    logic [1:0]  e_grant;
    logic [31:0] e_adr;
    logic [18:0] e_req;

    idle_all();
    rst_n = 1'b0;
    #7;
    settle();
    rst_n = 1'b1;
    owner = -1; last = 1; waited = 0; abrt = 0;
    cq[0] = 0; cq[1] = 0;

    for (int n = 0; n < 400; n++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) cq[m] = ~cq[m];
        st[m] = cq[m] && ($urandom_range(0, 3) != 0);
        ra[m] = $urandom;
        rd[m] = 16'($urandom);
        rs[m] = 2'($urandom);
        rw[m] = 1'($urandom);
      end
      ack = ($urandom_range(0, 4) == 0);
      m0.cyc = cq[0]; m0.stb = st[0]; m0.adr = ra[0];
      m0.dat_w = rd[0]; m0.sel = rs[0]; m0.we = rw[0];
      m1.cyc = cq[1]; m1.stb = st[1]; m1.adr = ra[1];
      m1.dat_w = rd[1]; m1.sel = rs[1]; m1.we = rw[1];
      sb.ack = ack;
      sb.dat_r = 16'($urandom);
      settle();

      stb_eff = (owner >= 0) && st[owner] && cq[owner] && !abrt;
      e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      e_adr = (owner >= 0) ? ra[owner] : 32'd0;
      e_req = (owner >= 0) ? {rw[owner], rs[owner], rd[owner]} : 19'd0;

      total_n++;
      if (grant !== e_grant)
        $display("FAIL rnd_grant[%0d]: got %b want %b", n, grant, e_grant);
      else pass_n++;
      total_n++;
      if ({sb.cyc, sb.stb} !== {(owner >= 0) && cq[owner] && !abrt, stb_eff})
        $display("FAIL rnd_cyc_stb[%0d]: got %b%b want %b%b", n, sb.cyc, sb.stb,
                 (owner >= 0) && cq[owner] && !abrt, stb_eff);
      else pass_n++;
      total_n++;
      if (sb.adr !== e_adr)
        $display("FAIL rnd_adr[%0d]: got %h want %h", n, sb.adr, e_adr);
      else pass_n++;
      total_n++;
      if ({sb.we, sb.sel, sb.dat_w} !== e_req)
        $display("FAIL rnd_req[%0d]: got %h want %h", n, {sb.we, sb.sel, sb.dat_w}, e_req);
      else pass_n++;
      total_n++;
      if ({m1.ack, m0.ack} !== {owner == 1 && stb_eff && ack, owner == 0 && stb_eff && ack})
        $display("FAIL rnd_ack[%0d]: got %b%b want %b%b", n, m1.ack, m0.ack,
                 owner == 1 && stb_eff && ack, owner == 0 && stb_eff && ack);
      else pass_n++;
      total_n++;
      if ({m1.err, m0.err, tmo} !== {owner == 1 && abrt, owner == 0 && abrt, abrt})
        $display("FAIL rnd_err[%0d]: got %b%b%b want %b%b%b", n, m1.err, m0.err, tmo,
                 owner == 1 && abrt, owner == 0 && abrt, abrt);
      else pass_n++;

      new_abrt = stb_eff && !ack && (waited == TO - 1);
      waited = (!stb_eff || ack || new_abrt) ? 0 : waited + 1;
      abrt = new_abrt;
      if (owner < 0) begin
        if (cq[0] && cq[1]) owner = 1 - last;
        else if (cq[0]) owner = 0;
        else if (cq[1]) owner = 1;
        if (owner >= 0) last = owner;
      end else if (!cq[owner]) begin
        owner = -1;
      end
    end
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_n, total_n);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_lock();
    test_timeout();
    test_tie();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
